// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin arbiter that merges N AXI-Stream requesters onto a single
// byte stream feeding a UART TX bridge. Each port keeps its grant for a whole
// packet. A starvation timer frees a grant whose owner stops presenting data,
// but it does not count cycles where the consumer is applying backpressure.
module axis_uart_tx_arbiter #(
    parameter int N_PORTS      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [N_PORTS-1:0]            S_AXIS_TVALID,
    input  logic [N_PORTS-1:0]            S_AXIS_TLAST,
    output logic [N_PORTS-1:0]            S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TLAST,
    input  logic                          M_AXIS_TREADY,
    output logic [$clog2(N_PORTS)-1:0]    M_AXIS_TID,
    output logic [N_PORTS-1:0]            GRANT,
    output logic                          TIMEOUT_EVENT
);

    localparam int ID_W  = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   tid;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   pick;
    logic              pick_vld;
    logic [CNT_W-1:0]  starve_cnt;
    logic [N_PORTS-1:0] grant;
    logic              timeout_pulse;
    logic [DATA_WIDTH-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              beat;
    logic              starved;
    logic              timeout_hit;
    int                idx;

    assign M_AXIS_TID    = tid;
    assign GRANT         = grant;
    assign TIMEOUT_EVENT = timeout_pulse;
    assign M_AXIS_TDATA  = sel_data;

    // Mux the stream of the port indexed by the (held) grant index.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (tid == ID_W'(i)) begin
                sel_data  = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = S_AXIS_TVALID[i];
                sel_last  = S_AXIS_TLAST[i];
            end
        end
    end

    // Round-robin search starting just after the last granted port; the
    // descending sweep lets the nearest candidate overwrite farther ones.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = N_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_PORTS;
            for (int j = 0; j < N_PORTS; j++) begin
                if (j == idx && S_AXIS_TVALID[j]) begin
                    pick     = ID_W'(j);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    assign beat        = (state == GRANTED) && sel_valid && M_AXIS_TREADY;
    assign starved     = (state == GRANTED) && !sel_valid;
    assign timeout_hit = starved && (starve_cnt == CNT_W'(IDLE_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and stream handshake outputs; packet end beats timeout.
    always_comb begin
        state_next    = state;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = '0;
        case (state)
            IDLE: begin
                if (pick_vld) state_next = GRANTED;
            end
            GRANTED: begin
                M_AXIS_TVALID = sel_valid;
                M_AXIS_TLAST  = sel_last;
                for (int i = 0; i < N_PORTS; i++) begin
                    if (tid == ID_W'(i)) S_AXIS_TREADY[i] = M_AXIS_TREADY;
                end
                if (beat && sel_last) state_next = IDLE;
                else if (timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant bookkeeping, starvation counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant         <= '0;
            tid           <= '0;
            last_grant    <= ID_W'(N_PORTS - 1);
            starve_cnt    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant      <= N_PORTS'(1) << pick;
                        tid        <= pick;
                        starve_cnt <= '0;
                    end
                end
                GRANTED: begin
                    if (beat && sel_last) begin
                        grant      <= '0;
                        last_grant <= tid;
                        starve_cnt <= '0;
                    end else if (timeout_hit) begin
                        grant         <= '0;
                        last_grant    <= tid;
                        starve_cnt    <= '0;
                        timeout_pulse <= 1'b1;
                    end else if (beat) begin
                        starve_cnt <= '0;
                    end else if (starved && starve_cnt != {CNT_W{1'b1}}) begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Directed bench for axis_uart_tx_arbiter: round-robin order, single-port
// regrant, starvation timeout, backpressure hold, late TLAST near timeout,
// and reset in the middle of a packet.
module tb_axis_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk;
    logic            reset;
    logic [N*DW-1:0] S_AXIS_TDATA;
    logic [N-1:0]    S_AXIS_TVALID;
    logic [N-1:0]    S_AXIS_TLAST;
    logic [N-1:0]    S_AXIS_TREADY;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic [1:0]      M_AXIS_TID;
    logic [N-1:0]    GRANT;
    logic            TIMEOUT_EVENT;

    int total;
    int bad;
    int beats[N];

    axis_uart_tx_arbiter #(
        .N_PORTS(N), .DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .S_AXIS_TDATA(S_AXIS_TDATA),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TID(M_AXIS_TID),
        .GRANT(GRANT),
        .TIMEOUT_EVENT(TIMEOUT_EVENT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-port data is {port, beat}; TLAST on the third beat.
    task automatic set_data();
        for (int i = 0; i < N; i++) begin
            S_AXIS_TDATA[i*DW +: DW] = {4'(i), 4'(beats[i])};
            S_AXIS_TLAST[i]          = (beats[i] == 2);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(GRANT), 0);
        chk({tag, "_mvalid"}, 32'(M_AXIS_TVALID), 0);
        chk({tag, "_mlast"}, 32'(M_AXIS_TLAST), 0);
        chk({tag, "_sready"}, 32'(S_AXIS_TREADY), 0);
        chk({tag, "_tid"}, 32'(M_AXIS_TID), 0);
        chk({tag, "_tev"}, 32'(TIMEOUT_EVENT), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        int   ep;
        total = 0;
        bad   = 0;
        for (int i = 0; i < N; i++) beats[i] = 0;

        // Reset state
        reset         = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        M_AXIS_TREADY = 1'b1;
        tick();
        tick();
        chk_reset_vals("rst");

        // Round robin over four ports, 3-beat packets
        reset         = 1'b0;
        S_AXIS_TVALID = 4'hF;
        set_data();
        #1;
        chk("rr_first_idle", 32'(M_AXIS_TVALID), 0);
        for (int p = 0; p < 5; p++) begin
            ep = p % N;
            for (int b = 0; b < 3; b++) begin
                tick();
                set_data();
                #1;
                chk("rr_grant", 32'(GRANT), 32'(1) << ep);
                chk("rr_tid", 32'(M_AXIS_TID), 32'(ep));
                chk("rr_mvalid", 32'(M_AXIS_TVALID), 1);
                chk("rr_data", 32'(M_AXIS_TDATA), 32'((ep << 4) | b));
                chk("rr_last", 32'(M_AXIS_TLAST), 32'(b == 2));
                chk("rr_sready", 32'(S_AXIS_TREADY), 32'(1) << ep);
                beats[ep] = (beats[ep] + 1) % 3;
            end
            tick();
            set_data();
            #1;
            chk("rr_dead_grant", 32'(GRANT), 0);
            chk("rr_dead_mvalid", 32'(M_AXIS_TVALID), 0);
        end

        // Only port 2, single-beat packets
        S_AXIS_TVALID = 4'b0100;
        S_AXIS_TLAST  = 4'b0100;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("p2_grant", 32'(GRANT), 4'b0100);
            chk("p2_tid", 32'(M_AXIS_TID), 2);
            chk("p2_last", 32'(M_AXIS_TLAST), 1);
            tick();
            chk("p2_gap", 32'(GRANT), 0);
        end
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;

        // Port 1 sends one beat then starves
        S_AXIS_TVALID = 4'b0010;
        tick();
        chk("to_grant", 32'(GRANT), 4'b0010);
        chk("to_sready", 32'(S_AXIS_TREADY), 4'b0010);
        tick();
        S_AXIS_TVALID = '0;
        #1;
        ok = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            if (k > 1) tick();
            if (k == TO) begin
                S_AXIS_TVALID = 4'b0100;
                S_AXIS_TLAST  = 4'b0100;
                #1;
            end
            if (GRANT !== 4'b0010 || TIMEOUT_EVENT !== 1'b0) ok = 1'b0;
        end
        chk("to_held_16", 32'(ok), 1);
        tick();
        chk("to_release", 32'(GRANT), 0);
        chk("to_event", 32'(TIMEOUT_EVENT), 1);
        tick();
        chk("to_event_once", 32'(TIMEOUT_EVENT), 0);
        chk("to_next_grant", 32'(GRANT), 4'b0100);
        chk("to_next_tid", 32'(M_AXIS_TID), 2);
        tick();
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        #1;
        chk("to_p2_done", 32'(GRANT), 0);

        // Backpressure on port 3 for 5000 cycles, port 0 also requesting
        S_AXIS_TVALID = 4'b1001;
        M_AXIS_TREADY = 1'b0;
        tick();
        chk("bp_grant", 32'(GRANT), 4'b1000);
        chk("bp_tid", 32'(M_AXIS_TID), 3);
        ok = 1'b1;
        repeat (5000) begin
            tick();
            if (GRANT !== 4'b1000 || S_AXIS_TREADY !== 4'b0000 ||
                TIMEOUT_EVENT !== 1'b0 || M_AXIS_TVALID !== 1'b1) ok = 1'b0;
        end
        chk("bp_hold", 32'(ok), 1);
        M_AXIS_TREADY = 1'b1;
        S_AXIS_TLAST  = 4'b1000;
        #1;
        chk("bp_sready", 32'(S_AXIS_TREADY), 4'b1000);
        chk("bp_last", 32'(M_AXIS_TLAST), 1);
        tick();
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        #1;
        chk("bp_release", 32'(GRANT), 0);
        chk("bp_tev", 32'(TIMEOUT_EVENT), 0);

        // TLAST arrives on the cycle the counter sits at IDLE_TIMEOUT-1
        S_AXIS_TVALID = 4'b0001;
        tick();
        chk("tl_grant", 32'(GRANT), 4'b0001);
        tick();
        S_AXIS_TVALID = '0;
        for (int k = 2; k <= TO; k++) tick();
        S_AXIS_TVALID = 4'b0001;
        S_AXIS_TLAST  = 4'b0001;
        #1;
        chk("tl_still_granted", 32'(GRANT), 4'b0001);
        chk("tl_mlast", 32'(M_AXIS_TLAST), 1);
        tick();
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        #1;
        chk("tl_release", 32'(GRANT), 0);
        chk("tl_no_tev", 32'(TIMEOUT_EVENT), 0);
        tick();
        chk("tl_no_tev2", 32'(TIMEOUT_EVENT), 0);

        // Reset in the middle of a port 3 packet
        S_AXIS_TVALID = 4'b1000;
        tick();
        chk("mr_grant", 32'(GRANT), 4'b1000);
        tick();
        chk("mr_grant2", 32'(GRANT), 4'b1000);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        S_AXIS_TVALID = 4'b1001;
        #1;
        chk_reset_vals("mr");
        tick();
        chk("mr_regrant", 32'(GRANT), 4'b0001);
        chk("mr_tid", 32'(M_AXIS_TID), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
